// File: rtl/piso_stream_serializer.sv
// ============================================================================
// Module   : piso_stream_serializer
// Purpose  : Parallel-in / serial-out converter with valid/ready on both sides,
//            per-word bit order and beat count, zero-bubble word chaining.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module piso_stream_serializer #(
  parameter  int WIDTH = 8,
  parameter  int LANES = 1,
  localparam int BEATS = WIDTH / LANES,
  localparam int CW    = $clog2(BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_msb_first,
  input  logic [CW-1:0]    in_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LANES-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam logic [0:0]    c_idle  = 1'b0;
  localparam logic [0:0]    c_shift = 1'b1;
  localparam logic [CW-1:0] c_beats = CW'(BEATS);

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [WIDTH-1:0] r_sr;
  logic [CW-1:0]    r_cnt;
  logic             r_msb;
  logic [CW-1:0]    w_cnt_load;
  logic             w_load;
  logic             w_xfer;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: a final beat with a simultaneous load stays in SHIFT
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle: begin
        if (w_load) w_state_nxt = c_shift;
      end
      c_shift: begin
        if (w_xfer && out_last && !w_load) w_state_nxt = c_idle;
      end
      default: w_state_nxt = c_idle;
    endcase
  end

  // Output logic
  always_comb begin
    out_valid = (r_state == c_shift);
    busy      = (r_state == c_shift);
    out_last  = (r_state == c_shift) && (r_cnt == '0);
    in_ready  = (r_state == c_idle) || (out_valid && out_ready && out_last);
    out_data  = '0;
    if (out_valid) begin
      out_data = r_msb ? r_sr[WIDTH-1 -: LANES] : r_sr[LANES-1:0];
    end
  end

  assign w_load = in_valid && in_ready;
  assign w_xfer = out_valid && out_ready;

  // Zero or out-of-range length means a full word
  always_comb begin
    if ((in_len == '0) || (in_len > c_beats)) begin
      w_cnt_load = c_beats - CW'(1);
    end else begin
      w_cnt_load = in_len - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr  <= '0;
      r_cnt <= '0;
      r_msb <= 1'b0;
    end else if (w_load) begin
      r_sr  <= in_data;
      r_cnt <= w_cnt_load;
      r_msb <= in_msb_first;
    end else if (w_xfer) begin
      r_sr <= r_msb ? (r_sr << LANES) : (r_sr >> LANES);
      if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule

`default_nettype wire
